mem_access_ctrl: RTL and testbench

//   Initiator for the calculator's synchronous operand/result memory (cs/we/oe, registered read).

---
 rtl/mem_access_ctrl.sv | 103 ++++++++++
 tb/tb_mem_access_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Request/response initiator for the calculator's synchronous operand/result memory.
// It sequences cs/we/oe for one read or write at a time and returns one response per request.
module mem_access_ctrl #(
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_we,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_cs,
   output logic              mem_we,
   output logic              mem_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StRdIssue,
      StRdCapture,
      StResp
   } state_e;

   state_e state;

   assign req_ready = (state == StIdle);

   // Strobes are registered alongside the state, so each one is a pure function of the
   // current state and never glitches; mem_rdata is sampled only when leaving StRdCapture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         mem_cs    <= 1'b0;
         mem_we    <= 1'b0;
         mem_oe    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_we    <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (req_valid) begin
                  mem_addr  <= req_addr;
                  mem_wdata <= req_wdata;
                  mem_cs    <= 1'b1;
                  if (req_we) begin
                     mem_we <= 1'b1;
                     state  <= StWrite;
                  end else begin
                     state  <= StRdIssue;
                  end
               end
            end
            StWrite: begin
               mem_cs    <= 1'b0;
               mem_we    <= 1'b0;
               rsp_we    <= 1'b1;
               rsp_rdata <= '0;
               rsp_valid <= 1'b1;
               state     <= StResp;
            end
            StRdIssue: begin
               mem_oe <= 1'b1;
               state  <= StRdCapture;
            end
            StRdCapture: begin
               mem_cs    <= 1'b0;
               mem_oe    <= 1'b0;
               rsp_we    <= 1'b0;
               rsp_rdata <= mem_rdata;
               rsp_valid <= 1'b1;
               state     <= StResp;
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: begin
               mem_cs    <= 1'b0;
               mem_we    <= 1'b0;
               mem_oe    <= 1'b0;
               rsp_valid <= 1'b0;
               state     <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a behavioural synchronous memory, a last-written-value
// reference model, and directed plus random request sequences.
module tb_mem_access_ctrl;

   localparam int unsigned AW = 2;
   localparam int unsigned DW = 16;
   localparam int unsigned T  = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready, rsp_we;
   logic [DW-1:0] rsp_rdata;
   logic          mem_cs, mem_we, mem_oe;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_we    (rsp_we),
      .rsp_rdata (rsp_rdata),
      .mem_cs    (mem_cs),
      .mem_we    (mem_we),
      .mem_oe    (mem_oe),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #(T / 2) clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural memory: registered read, drives junk whenever oe is low.
   logic [DW-1:0] mem [4];
   logic [DW-1:0] rd_q = '0;
   logic [DW-1:0] junk = '0;
   assign mem_rdata = mem_oe ? rd_q : junk;

   always @(negedge clk) junk <= DW'($urandom);

   int            wr_cnt = 0;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   always @(posedge clk) begin
      if (mem_cs && mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr_cnt  = wr_cnt + 1;
         wr_addr = mem_addr;
         wr_data = mem_wdata;
      end else if (mem_cs) begin
         rd_q <= mem[mem_addr];
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("strobe_rules", 32'({mem_oe && mem_we, !mem_cs && (mem_we || mem_oe)}), 32'd0);
      end
   end

   // Reference: each read returns the last word written to that address.
   logic [DW-1:0] ref_mem [4];
   int            prev_t   = 0;
   logic          prev_we  = 1'b0;
   logic          chk_int  = 1'b0;

   task automatic scramble();
      req_we    = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
   endtask

   // Called at a negedge; returns at the negedge where the response is first visible.
   task automatic xact(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int            n;
      int            lat;
      int            t_acc;
      int            wr_before;
      logic [DW-1:0] exp;
      wr_before = wr_cnt;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      @(posedge clk);
      t_acc = int'($time);
      @(negedge clk);
      req_valid = 1'b0;
      scramble();
      chk("busy_req_ready", 32'(req_ready), 32'd0);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         scramble();
         lat++;
      end
      chk(we ? "wr_latency" : "rd_latency", 32'(lat), we ? 32'd2 : 32'd3);
      if (we) begin
         ref_mem[a] = d;
         exp = '0;
      end else begin
         exp = ref_mem[a];
      end
      chk("rsp_we", 32'(rsp_we), 32'(we));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp));
      chk("write_cycles", 32'(wr_cnt - wr_before), 32'(we));
      if (we) begin
         chk("wr_addr", 32'(wr_addr), 32'(a));
         chk("wr_data", 32'(wr_data), 32'(d));
      end
      if (chk_int) begin
         chk("issue_interval", 32'(t_acc - prev_t), prev_we ? 32'(3 * T) : 32'(4 * T));
      end
      prev_t  = t_acc;
      prev_we = we;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_we"}, 32'(rsp_we), 32'd0);
      chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
      chk({tag, "_strobes"}, 32'({mem_cs, mem_we, mem_oe}), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
   endtask

   initial begin
      #(200000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] held;
      logic [AW-1:0] ra;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      #12;
      chk_reset_outputs("por");
      rst = 1'b0;
      @(negedge clk);

      // Write then read back one word.
      xact(1'b1, 2'd2, 16'h1234);
      xact(1'b0, 2'd2, 16'h0000);

      // Boundary values, back-to-back with rsp_ready held high.
      xact(1'b1, 2'd0, 16'h8000);
      chk_int = 1'b1;
      xact(1'b1, 2'd1, 16'h7FFF);
      xact(1'b1, 2'd2, 16'hFFFF);
      xact(1'b1, 2'd3, 16'h0001);
      for (int i = 3; i >= 0; i--) xact(1'b0, AW'(i), 16'h0000);
      chk_int = 1'b0;

      // Backpressure on a read response.
      @(negedge clk);
      rsp_ready = 1'b0;
      xact(1'b0, 2'd1, 16'h0000);
      held = ref_mem[1];
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rsp_rdata", 32'(rsp_rdata), 32'(held));
         chk("hold_req_ready", 32'(req_ready), 32'd0);
         chk("hold_mem_cs", 32'(mem_cs), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("release_req_ready", 32'(req_ready), 32'd1);

      // Mid-cycle reset while a write response is held.
      rsp_ready = 1'b0;
      xact(1'b1, 2'd1, 16'hBEEF);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;

      // Reset during the capture cycle of a read discards it.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 2'd2;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("pre_rst_oe", 32'(mem_oe), 32'd1);
      rst = 1'b1;
      #1;
      chk("cap_rst_strobes", 32'({mem_cs, mem_we, mem_oe}), 32'd0);
      chk("cap_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("cap_rst_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      xact(1'b0, 2'd2, 16'h0000);
      xact(1'b0, 2'd1, 16'h0000);

      // Random mix with interval checking.
      chk_int = 1'b0;
      for (int i = 0; i < 24; i++) begin
         ra = AW'($urandom);
         xact(1'($urandom), ra, DW'($urandom));
         chk_int = 1'b1;
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
